sample_sequencer: RTL

Training-loop controller that sequences the backprop pipeline. It walks sample indices 0..SAMPLE_NUM-1 for a programmed number of epochs and issues each index first to the forward-path input fetcher. It then feeds the same index, in order, to the error_fetcher sample port, and caps the number of samples in flight until the delta for each sample has been consumed. It sits above error_fetcher and the forward datapath and reports done, progress and sticky overflow errors.

---
 rtl/sample_sequencer_pkg.sv | 10 +
 rtl/sample_index_fifo.sv | 42 ++++
 rtl/sample_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/sample_sequencer_pkg.sv
// sample_sequencer_pkg: FSM state encoding and sizing helper shared by the sequencer and its index FIFO
package sample_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction
endpackage

// File: rtl/sample_index_fifo.sv
// sample_index_fifo: synchronous valid/ready FIFO holding issued sample indices until error_fetcher takes them
module sample_index_fifo
   import sample_sequencer_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_valid,
   output logic             push_ready,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   input  logic             pop_ready
);
   localparam int AW = DEPTH > 1 ? clog2(DEPTH) : 1;
   localparam int CW = clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic push, pop;
   assign pop_valid = count != '0;
   assign push_ready = count != CW'(DEPTH) || pop_ready;
   assign push = push_valid && push_ready;
   assign pop = pop_valid && pop_ready;
   assign pop_data = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: walks sample indices over epochs, issues them to the forward path and replays them in order
// to error_fetcher while capping the number of samples whose delta has not yet been retired
module sample_sequencer
   import sample_sequencer_pkg::*;
#(
   parameter int SAMPLE_ADDR_SIZE = 10,
   parameter int SAMPLE_NUM = 1000,
   parameter int EPOCH_WIDTH = 16,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [EPOCH_WIDTH-1:0]      epoch_count,
   output logic                        busy,
   output logic                        done,
   output logic [EPOCH_WIDTH-1:0]      epoch_index,
   output logic [SAMPLE_ADDR_SIZE-1:0] fwd_sample_index,
   output logic                        fwd_sample_index_valid,
   input  logic                        fwd_sample_index_ready,
   output logic [SAMPLE_ADDR_SIZE-1:0] err_sample_index,
   output logic                        err_sample_index_valid,
   input  logic                        err_sample_index_ready,
   input  logic                        delta_retire,
   input  logic                        error,
   output logic                        error_flag
);
   localparam int IW = clog2(MAX_INFLIGHT + 1);
   localparam logic [SAMPLE_ADDR_SIZE-1:0] LAST_SAMPLE = SAMPLE_ADDR_SIZE'(SAMPLE_NUM - 1);
   seq_state_t state;
   logic [EPOCH_WIDTH-1:0] epochs;
   logic [IW-1:0] inflight;
   logic fifo_ready, fifo_valid, fwd_fire, retire, last_sample, last_epoch;
   // fifo_ready is redundant with the inflight cap (a full FIFO implies a full cap) but keeps the push guarded
   assign fwd_sample_index_valid = state == ISSUE && inflight < IW'(MAX_INFLIGHT) && fifo_ready;
   assign fwd_fire = fwd_sample_index_valid && fwd_sample_index_ready;
   assign retire = delta_retire && inflight != '0;
   assign last_sample = fwd_sample_index == LAST_SAMPLE;
   assign last_epoch = epoch_index == epochs - EPOCH_WIDTH'(1);
   assign err_sample_index_valid = fifo_valid;
   sample_index_fifo #(.WIDTH(SAMPLE_ADDR_SIZE), .DEPTH(MAX_INFLIGHT)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_data  (fwd_sample_index),
      .push_valid (fwd_fire),
      .push_ready (fifo_ready),
      .pop_data   (err_sample_index),
      .pop_valid  (fifo_valid),
      .pop_ready  (err_sample_index_ready)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         epochs <= '0;
         epoch_index <= '0;
         fwd_sample_index <= '0;
         inflight <= '0;
         error_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         inflight <= inflight + IW'(fwd_fire) - IW'(retire);
         if (busy && error) error_flag <= 1'b1;
         case (state)
            IDLE: if (start) begin
               epochs <= epoch_count;
               error_flag <= 1'b0;
               epoch_index <= '0;
               fwd_sample_index <= '0;
               busy <= 1'b1;
               state <= (epoch_count == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
               if (fwd_fire) begin
                  fwd_sample_index <= last_sample ? '0 : fwd_sample_index + SAMPLE_ADDR_SIZE'(1);
                  if (last_sample && !last_epoch) epoch_index <= epoch_index + EPOCH_WIDTH'(1);
               end
               if (error || (fwd_fire && last_sample && last_epoch)) state <= DRAIN;
            end
            DRAIN: if (inflight == '0 && !fifo_valid) state <= DONE;
            DONE: begin
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
